// File: rtl/rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin arbiter.
// Optional lock feature is controlled by RR_ARB_LOCK_EN.
package arb_pkg;

  localparam int N_MAX = 64;

  // The index width is at least one bit, so N=1 still gets a usable index port.
  function automatic int calc_iw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and rr_arbiter.
// lock_i is present only when RR_ARB_LOCK_EN is defined.
interface rr_arbiter_if
  import arb_pkg::*;
#(
  parameter int N = 32
) ();
  localparam int IW = calc_iw(N);

  logic [N-1:0]  req_i;
`ifdef RR_ARB_LOCK_EN
  logic [N-1:0]  lock_i;
`endif
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;
  logic          gnt_valid_o;

  modport slave (
`ifdef RR_ARB_LOCK_EN
    input  lock_i,
`endif
    input  req_i,
    output gnt_o, gnt_idx_o, gnt_valid_o
  );

  modport master (
`ifdef RR_ARB_LOCK_EN
    output lock_i,
`endif
    output req_i,
    input  gnt_o, gnt_idx_o, gnt_valid_o
  );
endinterface

// File: rtl/rr_arbiter_prio_enc.sv
// Rotating priority encoder: the first set req bit at or above ptr_i wins,
// wrapping to bit 0. Purely combinational.
module prio_enc_rot
  import arb_pkg::*;
#(
  parameter  int N  = 32,
  localparam int IW = calc_iw(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  win_oh_o,
  output logic [IW-1:0] win_idx_o,
  output logic          win_vld_o
);

  logic [2*N-1:0] dbl;

  // Lower copy is masked below ptr; the upper copy supplies the wrapped bits.
  always_comb begin
    dbl = {req_i, req_i};
    for (int i = 0; i < N; i++)
      if (i < int'(ptr_i)) dbl[i] = 1'b0;

    win_vld_o = 1'b0;
    win_idx_o = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (!win_vld_o && dbl[i]) begin
        win_vld_o = 1'b1;
        win_idx_o = IW'((i >= N) ? (i - N) : i);
      end
    end

    win_oh_o = win_vld_o ? (N'(1) << win_idx_o) : '0;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and encoded index.
// Define RR_ARB_LOCK_EN to add lock_i with a MAX_HOLD-bounded grant hold.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  rr_arbiter_if.slave  bus
);

  localparam int IW = calc_iw(N);

  if (N < 1 || N > N_MAX) begin : g_bad_n
    $error("rr_arbiter: N out of range");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("rr_arbiter: MAX_HOLD must be >= 1");
  end

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          vld_q, vld_d;

  logic [N-1:0]  win_oh;
  logic [IW-1:0] win_idx;
  logic          win_vld;

  prio_enc_rot #(.N(N)) u_enc (
    .req_i     (bus.req_i),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .win_vld_o (win_vld)
  );

`ifdef RR_ARB_LOCK_EN
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          keep;

  // The current holder keeps the grant only while it requests, locks and has budget left.
  assign keep = vld_q && |(bus.req_i & gnt_q) && |(bus.lock_i & gnt_q)
                && (hold_q < HW'(MAX_HOLD - 1));
`endif

  always_comb begin
    gnt_d = win_oh;
    idx_d = win_idx;
    vld_d = win_vld;
    ptr_d = ptr_q;
    if (win_vld)
      ptr_d = (win_idx == IW'(N - 1)) ? '0 : IW'(win_idx + 1'b1);
`ifdef RR_ARB_LOCK_EN
    hold_d = '0;
    if (keep) begin
      gnt_d  = gnt_q;
      idx_d  = idx_q;
      vld_d  = 1'b1;
      ptr_d  = ptr_q;
      hold_d = hold_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      gnt_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end

`ifdef RR_ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_q <= '0;
    else          hold_q <= hold_d;
  end
`endif

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.gnt_valid_o = vld_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: N=4 (MAX_HOLD=3), N=8 and N=1 instances.
// Lock scenarios run only when RR_ARB_LOCK_EN is defined.
module tb_rr_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int idx;
    bit v;
  } exp_t;

  exp_t q4[$], q8[$], q1[$];

  rr_arbiter_if #(.N(4)) if4 ();
  rr_arbiter_if #(.N(8)) if8 ();
  rr_arbiter_if #(.N(1)) if1 ();

  rr_arbiter #(.N(4), .MAX_HOLD(3)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4.slave));
  rr_arbiter #(.N(8))               u8 (.clk(clk), .reset_n(reset_n), .bus(if8.slave));
  rr_arbiter #(.N(1))               u1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] oh(input int idx, input bit v);
    logic [63:0] one;
    one = 64'd1;
    return v ? (one << idx) : 64'd0;
  endfunction

  // Drivers: called at a negedge, set inputs, queue the result expected after the next posedge.
  task automatic s4(input logic [3:0] r, input int idx, input bit v);
    exp_t e;
    if4.req_i = r;
    e.idx = idx; e.v = v;
    q4.push_back(e);
    @(negedge clk);
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic s4l(input logic [3:0] r, input logic [3:0] l, input int idx, input bit v);
    if4.lock_i = l;
    s4(r, idx, v);
  endtask
`endif

  task automatic s8(input logic [7:0] r, input int idx, input bit v);
    exp_t e;
    if8.req_i = r;
    e.idx = idx; e.v = v;
    q8.push_back(e);
    @(negedge clk);
  endtask

  task automatic s1(input logic r, input bit v);
    exp_t e;
    if1.req_i = r;
    e.idx = 0; e.v = v;
    q1.push_back(e);
    @(negedge clk);
  endtask

  // Monitors: pop one expectation per edge while entries are pending.
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("n4_gnt", 64'(if4.gnt_o), oh(e.idx, e.v));
      chk("n4_idx", 64'(if4.gnt_idx_o), e.v ? 64'(e.idx) : 64'd0);
      chk("n4_vld", 64'(if4.gnt_valid_o), 64'(e.v));
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk("n8_gnt", 64'(if8.gnt_o), oh(e.idx, e.v));
      chk("n8_idx", 64'(if8.gnt_idx_o), e.v ? 64'(e.idx) : 64'd0);
      chk("n8_vld", 64'(if8.gnt_valid_o), 64'(e.v));
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("n1_gnt", 64'(if1.gnt_o), oh(0, e.v));
      chk("n1_vld", 64'(if1.gnt_valid_o), 64'(e.v));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    if4.req_i = 4'hF;
    if8.req_i = 8'h00;
    if1.req_i = 1'b0;
`ifdef RR_ARB_LOCK_EN
    if4.lock_i = 4'h0;
    if8.lock_i = 8'h0;
    if1.lock_i = 1'b0;
`endif

    // Reset held with every requester active.
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(if4.gnt_o), 64'd0);
    chk("rst_idx", 64'(if4.gnt_idx_o), 64'd0);
    chk("rst_vld", 64'(if4.gnt_valid_o), 64'd0);

    // Full rotation from index 0.
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) s4(4'b1111, i % 4, 1'b1);
    s4(4'b0000, 0, 1'b0);

    // Mid-operation async reset while requester 2 holds the grant.
    s4(4'b0100, 2, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(if4.gnt_o), 64'd0);
    chk("mid_rst_idx", 64'(if4.gnt_idx_o), 64'd0);
    chk("mid_rst_vld", 64'(if4.gnt_valid_o), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    s4(4'b1111, 0, 1'b1);
    s4(4'b0000, 0, 1'b0);

    // Sparse, wrap and non-sticky behaviour on N=8.
    s8(8'b1000_0001, 0, 1'b1);
    s8(8'b1000_0001, 7, 1'b1);
    s8(8'b1000_0001, 0, 1'b1);
    s8(8'b1000_0001, 7, 1'b1);
    s8(8'b0000_1000, 3, 1'b1);
    s8(8'b1111_1111, 4, 1'b1);
    s8(8'b1111_1111, 5, 1'b1);
    s8(8'b0100_0000, 6, 1'b1);
    s8(8'b0000_0001, 0, 1'b1);
    s8(8'b0000_0011, 1, 1'b1);
    s8(8'b0000_0011, 0, 1'b1);
    s8(8'b0000_0000, 0, 1'b0);

    // Single requester: grant follows request one cycle later.
    s1(1'b1, 1'b1);
    s1(1'b1, 1'b1);
    s1(1'b0, 1'b0);
    s1(1'b1, 1'b1);
    s1(1'b0, 1'b0);

`ifdef RR_ARB_LOCK_EN
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    // Locked holder 0 keeps the grant for MAX_HOLD cycles, then yields once.
    for (int r = 0; r < 2; r++) begin
      s4l(4'b0011, 4'b0001, 0, 1'b1);
      s4l(4'b0011, 4'b0001, 0, 1'b1);
      s4l(4'b0011, 4'b0001, 0, 1'b1);
      s4l(4'b0011, 4'b0001, 1, 1'b1);
    end
    // Sole locked requester stays granted across forced releases.
    for (int i = 0; i < 8; i++) s4l(4'b0001, 4'b0001, 0, 1'b1);
    s4l(4'b0000, 4'b0000, 0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #2;
    if (q4.size() + q8.size() + q1.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q4.size() + q8.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
